// File: rtl/sprite_line_scanner_if.sv
// Request/result bundle between the line renderer (master) and the sprite line scanner (slave).
// Handshake: start is a one-cycle request that is always accepted (it also aborts a running scan);
// busy is high while scanning, and line_prepared high means BufferArray/obj_count/overflow are valid and stable.
interface sprite_line_scanner_if #(
  parameter int MAX_PER_LINE  = 32,
  parameter int OAM_ADDR_SIZE = 6,
  parameter int COORD_W       = 10
);
  logic                                       start;
  logic [COORD_W-1:0]                         target_line;
  logic                                       tall_mode;
  logic [MAX_PER_LINE*(OAM_ADDR_SIZE+1)-1:0]  BufferArray;
  logic [$clog2(MAX_PER_LINE+1)-1:0]          obj_count;
  logic                                       busy;
  logic                                       line_prepared;
  logic                                       overflow;
  logic [1:0]                                 dbg_state;

  modport master (
    output start, target_line, tall_mode,
    input  BufferArray, obj_count, busy, line_prepared, overflow, dbg_state
  );

  modport slave (
    input  start, target_line, tall_mode,
    output BufferArray, obj_count, busy, line_prepared, overflow, dbg_state
  );
endinterface

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite evaluator: walks OAM and collects up to MAX_PER_LINE objects covering a line.
// Optional macro SPRITE_OVERFLOW_SCAN_EN keeps scanning past a full buffer to report overflow.
module sprite_line_scanner #(
  parameter int MAX_PER_LINE    = 32,
  parameter int OAM_MAX_OBJECTS = 64,
  parameter int OAM_ADDR_SIZE   = 6,
  parameter int COORD_W         = 10,
  parameter int SPRITE_HEIGHT   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              oam_data,
  output logic [OAM_ADDR_SIZE-1:0] oam_addr,
  sprite_line_scanner_if.slave     bus
);

  localparam int SW = OAM_ADDR_SIZE + 1;
  localparam int CW = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state;
  logic [COORD_W-1:0]            line_q;
  logic                          tall_q;
  logic                          issuing;
  logic                          pend_valid;
  logic [OAM_ADDR_SIZE-1:0]      pend_idx;
  logic [MAX_PER_LINE*SW-1:0]    buf_q;
  logic [CW-1:0]                 count_q;
  logic                          busy_q;
  logic                          prep_q;

  logic [COORD_W-1:0]            obj_y;
  logic [COORD_W:0]              height;
  logic                          hit;
  logic                          last_eval;
  logic                          scan_finish;
  logic                          set_ovf;

  // Compare one bit wider than the coordinate so Y+H cannot wrap past the top line.
  assign obj_y     = oam_data[30 -: COORD_W];
  assign height    = tall_q ? (COORD_W+1)'(2*SPRITE_HEIGHT) : (COORD_W+1)'(SPRITE_HEIGHT);
  assign hit       = oam_data[31]
                   && ({1'b0, line_q} >= {1'b0, obj_y})
                   && ({1'b0, line_q} <  ({1'b0, obj_y} + height));
  assign last_eval = (pend_idx == OAM_ADDR_SIZE'(OAM_MAX_OBJECTS-1));

  always_comb begin
    scan_finish = 1'b0;
    set_ovf     = 1'b0;
    if (state == SCAN && pend_valid) begin
`ifdef SPRITE_OVERFLOW_SCAN_EN
      if (hit && count_q == CW'(MAX_PER_LINE)) begin
        scan_finish = 1'b1;
        set_ovf     = 1'b1;
      end else if (last_eval) begin
        scan_finish = 1'b1;
      end
`else
      if ((hit && count_q == CW'(MAX_PER_LINE-1)) || last_eval)
        scan_finish = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      line_q     <= '0;
      tall_q     <= 1'b0;
      issuing    <= 1'b0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      oam_addr   <= '0;
      buf_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      prep_q     <= 1'b0;
    end else if (bus.start) begin
      state      <= SCAN;
      line_q     <= bus.target_line;
      tall_q     <= bus.tall_mode;
      issuing    <= 1'b1;
      pend_valid <= 1'b0;
      oam_addr   <= '0;
      buf_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b1;
      prep_q     <= 1'b0;
    end else if (state == SCAN) begin
      // Fetch pipeline: the address presented this cycle is evaluated one edge later.
      pend_valid <= issuing;
      pend_idx   <= oam_addr;
      if (issuing) begin
        if (oam_addr == OAM_ADDR_SIZE'(OAM_MAX_OBJECTS-1))
          issuing <= 1'b0;
        else
          oam_addr <= oam_addr + OAM_ADDR_SIZE'(1);
      end
      if (pend_valid && hit && count_q != CW'(MAX_PER_LINE)) begin
        for (int i = 0; i < MAX_PER_LINE; i++) begin
          if (count_q == CW'(i))
            buf_q[i*SW +: SW] <= {pend_idx, 1'b1};
        end
        count_q <= count_q + CW'(1);
      end
      if (scan_finish) begin
        state      <= DONE;
        issuing    <= 1'b0;
        pend_valid <= 1'b0;
        busy_q     <= 1'b0;
        prep_q     <= 1'b1;
      end
    end
  end

`ifdef SPRITE_OVERFLOW_SCAN_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_q <= 1'b0;
    else if (bus.start)
      ovf_q <= 1'b0;
    else if (set_ovf)
      ovf_q <= 1'b1;
  end

  assign bus.overflow = ovf_q;
`else
  logic unused_set_ovf;
  assign unused_set_ovf = set_ovf;
  assign bus.overflow   = 1'b0;
`endif

  assign bus.BufferArray   = buf_q;
  assign bus.obj_count     = count_q;
  assign bus.busy          = busy_q;
  assign bus.line_prepared = prep_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Randomized bench for sprite_line_scanner against a list-based reference model of the selection rules.
module tb_sprite_line_scanner;

  localparam int MAX  = 32;
  localparam int N    = 64;
  localparam int A    = 6;
  localparam int CWD  = 10;
  localparam int H    = 16;
  localparam int SW   = A + 1;
`ifdef SPRITE_OVERFLOW_SCAN_EN
  localparam bit OVF_MODE = 1'b1;
`else
  localparam bit OVF_MODE = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [31:0]   oam_data;
  logic [A-1:0]  oam_addr;
  logic [31:0]   oam_mem [N];

  sprite_line_scanner_if #(.MAX_PER_LINE(MAX), .OAM_ADDR_SIZE(A), .COORD_W(CWD)) bus ();

  sprite_line_scanner #(
    .MAX_PER_LINE(MAX), .OAM_MAX_OBJECTS(N), .OAM_ADDR_SIZE(A),
    .COORD_W(CWD), .SPRITE_HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset), .oam_data(oam_data), .oam_addr(oam_addr), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous OAM with one cycle of read latency.
  always @(posedge clk) oam_data <= oam_mem[oam_addr];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [A-1:0] exp_q[$];
  bit           exp_ovf;
  int           exp_lat;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit en, input int y);
    logic [20:0] junk;
    junk = 21'($urandom);
    return {en, CWD'(y), junk};
  endfunction

  // Reference: list of hitting indices in OAM order, truncated at capacity.
  task automatic model(input int line, input bit tall);
    int hh;
    int hits;
    int y;
    hh = tall ? 2*H : H;
    hits = 0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_lat = N + 1;
    for (int k = 0; k < N; k++) begin
      y = int'(oam_mem[k][30:21]);
      if (oam_mem[k][31] && line >= y && line < y + hh) begin
        hits++;
        if (hits <= MAX) exp_q.push_back(A'(k));
        if (!OVF_MODE && hits == MAX) begin
          exp_lat = k + 2;
          break;
        end
        if (OVF_MODE && hits == MAX + 1) begin
          exp_ovf = 1'b1;
          exp_lat = k + 2;
          break;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_scan(input int line, input bit tall);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.target_line = CWD'(line);
    bus.tall_mode   = tall;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_check(input string tag);
    int cycles;
    logic [255:0] exp_buf;
    cycles = 0;
    check_eq({tag, "_busy"}, 256'(bus.busy), 256'(1));
    check_eq({tag, "_clear"}, 256'(bus.obj_count), 256'(0));
    while (!bus.line_prepared && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    exp_buf = '0;
    for (int i = 0; i < exp_q.size(); i++) exp_buf[i*SW +: SW] = {exp_q[i], 1'b1};
    check_eq({tag, "_latency"}, 256'(cycles), 256'(exp_lat));
    check_eq({tag, "_count"}, 256'(bus.obj_count), 256'(exp_q.size()));
    check_eq({tag, "_slots"}, 256'(bus.BufferArray), exp_buf);
    check_eq({tag, "_ovf"}, 256'(bus.overflow), 256'(exp_ovf));
    check_eq({tag, "_busy_done"}, 256'(bus.busy), 256'(0));
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_hold_prep"}, 256'(bus.line_prepared), 256'(1));
    check_eq({tag, "_hold_slots"}, 256'(bus.BufferArray), exp_buf);
  endtask

  task automatic run_scan(input string tag, input int line, input bit tall);
    model(line, tall);
    start_scan(line, tall);
    wait_check(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"}, 256'(oam_addr), 256'(0));
    check_eq({tag, "_slots"}, 256'(bus.BufferArray), 256'(0));
    check_eq({tag, "_count"}, 256'(bus.obj_count), 256'(0));
    check_eq({tag, "_busy"}, 256'(bus.busy), 256'(0));
    check_eq({tag, "_prep"}, 256'(bus.line_prepared), 256'(0));
    check_eq({tag, "_ovf"}, 256'(bus.overflow), 256'(0));
  endtask

  task automatic fill_random(input int line, input int spread);
    int y;
    for (int k = 0; k < N; k++) begin
      y = line - int'($urandom_range(0, spread));
      if (y < 0) y = int'($urandom_range(0, 1023));
      oam_mem[k] = mk($urandom_range(0, 3) != 0, y);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int la;
    int lb;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.target_line = '0;
    bus.tall_mode = 1'b0;
    for (int k = 0; k < N; k++) oam_mem[k] = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Empty OAM: full walk, nothing selected.
    run_scan("empty", 5, 1'b0);

    // Everything covers line 3: buffer fills (or overflows) early.
    for (int k = 0; k < N; k++) oam_mem[k] = mk(1'b1, 0);
    run_scan("allhit", 3, 1'b0);

    // Exactly 33 hits.
    for (int k = 0; k < N; k++) oam_mem[k] = mk(k <= 32, 0);
    run_scan("hit33", 3, 1'b0);

    // Two objects at Y=100: bottom line edge and tall mode.
    for (int k = 0; k < N; k++) oam_mem[k] = mk(1'b0, 100);
    oam_mem[7]  = mk(1'b1, 100);
    oam_mem[40] = mk(1'b1, 100);
    run_scan("edge115", 115, 1'b0);
    run_scan("edge116", 116, 1'b0);
    run_scan("tall116", 116, 1'b1);
    run_scan("above99", 99, 1'b1);

    // Top of coordinate range must not wrap.
    for (int k = 0; k < N; k++) oam_mem[k] = 32'h0;
    oam_mem[3]  = mk(1'b1, 1020);
    oam_mem[10] = mk(1'b1, 1023);
    run_scan("nowrap1023", 1023, 1'b0);
    run_scan("nowrap5", 5, 1'b0);

    // Restart mid-scan with a different line.
    la = 200;
    lb = 600;
    fill_random(la, 30);
    for (int k = 32; k < N; k++) oam_mem[k] = mk($urandom_range(0, 1) != 0, lb - int'($urandom_range(0, 20)));
    start_scan(la, 1'b0);
    repeat (19) @(posedge clk);
    model(lb, 1'b0);
    start_scan(lb, 1'b0);
    wait_check("restart");

    // Asynchronous reset in the middle of a scan.
    start_scan(la, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    run_scan("after_reset", lb, 1'b0);

    // Randomized rounds.
    for (int r = 0; r < 24; r++) begin
      la = int'($urandom_range(0, 1023));
      fill_random(la, ($urandom_range(0, 1) != 0) ? 20 : 60);
      run_scan($sformatf("rand%0d", r), la, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
